v35_intc: RTL
=============

Name: v35_intc

Overview:
- Interrupt controller and scheduler for the V35 CPU core.
- Holds one interrupt-control (IC) register per source plus the in-service priority register (ISPR).
- Picks the highest-priority eligible request, presents one vector to the core, and runs the ack/fini handshake.
- Replaces the ad-hoc EXIC handling in the V35 wrapper; the wrapper's SFR decoder maps IC/ISPR accesses onto this block's register port.

Parameters:
- N_SRC, 8: number of interrupt sources (1..8); index 0 = INTP0.
- VEC_BASE, 24: vector number of source 0; source i uses VEC_BASE+i, truncated to 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_cycle  in  1  CPU internal-clock enable; all state changes except register writes occur only when high
- src_in  in  N_SRC  raw source levels
- src_pol  in  N_SRC  active edge per source; 1 = rising, 0 = falling (driven from INTM)
- reg_wr  in  1  register write strobe, single clk, not ce-qualified
- reg_rd  in  1  register read strobe
- reg_addr  in  4  0..N_SRC-1 = IC[i]; 8 = ISPR; other addresses read 0, writes ignored
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data, registered
- irq_request  out  1  request to core
- irq_vector  out  8  vector number, valid while irq_request=1
- irq_ack  in  1  core accepted the request
- irq_fini  in  1  core executed FINT/RETI

Behaviour:
- IC[i] layout: [7] IF request flag, [6] MK mask (1 = masked), [2:0] PR priority (0 highest). Bits [5:3] read 0, writes ignored.
- Reset values: IC = 8'h47; ISPR = 0; state = IDLE; irq_request = 0; irq_vector = 0; reg_rdata = 0; edge history = current src_in.
- Edge detect, on ce_cycle: prev[i] <= src_in[i]. If src_in[i] != prev[i] and src_in[i] == src_pol[i], set IF[i].
- reg_wr to IC[i] writes bits 7,6,2:0. If an edge sets IF[i] in the same clk, final IF = written IF | 1.
- reg_wr to ISPR overwrites ISPR. This write loses to a same-clk ack/fini update.
- reg_rd: reg_rdata <= selected register on the next clk edge (1-cycle latency). Otherwise it holds.
- Eligible(i) = IF[i] & ~MK[i] & (ISPR[PR[i]:0] == 0). A request is eligible only if it is strictly higher priority than everything in service.
- Winner: lowest PR among eligible sources; on ties, lowest index.
- FSM has two states, updated on ce_cycle only:
  - IDLE: if any source is eligible, latch win_idx, set irq_vector = VEC_BASE+win_idx, irq_request = 1, go PEND. Selection uses flags as they were before this clk's edge updates, so an edge is visible on the next ce_cycle.
  - PEND, irq_ack = 1: ISPR[PR[win_idx]] <= 1, IF[win_idx] <= 0, irq_request <= 0, go IDLE. The earliest re-arbitration is the next ce_cycle.
  - PEND, irq_ack = 0 and Eligible(win_idx) = 0 (software cleared IF, set MK, or raised ISPR): drop, with irq_request <= 0, go IDLE. No vector change occurs while PEND.
  - PEND, irq_ack = 1 and the source became ineligible in the same clk: ack wins and the ack action is performed.
- irq_fini, on ce_cycle: clear the lowest-index set bit of ISPR. If ISPR = 0, no effect.
- irq_fini and irq_ack in the same ce_cycle: apply fini to the old ISPR, then OR in the ack bit.
- A higher-priority source arriving while PEND does not preempt the latched vector. It is served after the ack.
- irq_ack/irq_fini without ce_cycle are ignored. The core pulses them for one ce_cycle.
- Reset asserted mid-PEND: irq_request drops immediately (async). All IF flags clear to reset values.

Test Plan:
- Reset: read IC0..7 -> 8'h47 each, ISPR -> 0, irq_request = 0.
- Basic: write IC1 = 8'h03, src_pol[1] = 1, raise src_in[1] -> irq_request = 1, irq_vector = 25. Pulse irq_ack -> request drops, ISPR = 8'h08, IC1 reads 8'h03. irq_fini -> ISPR = 0.
- Priority and tie: IC0 = 8'h05, IC2 = 8'h02, IC3 = 8'h02, edge on 0, 2 and 3 in the same ce_cycle -> vector 26. After ack -> 27 is blocked while ISPR[2] = 1 (equal level). After fini -> vector 27, then 24.
- Nesting: with ISPR = 8'h10 (level 4 in service), PR = 5 is not requested and PR = 3 is requested. Ack -> ISPR = 8'h18. Fini -> 8'h10. Fini -> 0.
- Cancel vs ack: in PEND for source 1, write IC1 = 8'h43 -> irq_request = 0 next ce_cycle, ISPR unchanged. Repeat with irq_ack in the same clk as the write -> ISPR[3] set, IF cleared.
- Concurrent ack+fini: ISPR = 8'h04, PEND source PR = 1, ack and fini in one ce_cycle -> ISPR = 8'h02. Assert reset mid-PEND -> irq_request = 0 without clk edge.

Source files
------------

// File: rtl/v35_intc.sv
// v35_intc: interrupt controller / scheduler for the V35 CPU core.
// Holds one IC register per source plus the in-service priority register
// (ISPR), picks the highest-priority eligible request and runs the
// request / ack / fini handshake with the core.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ce_cycle            CPU clock enable; all non-register-write state moves on it
//   src_in, src_pol     raw source levels and active edge (1 = rising)
//   reg_wr, reg_rd      register port strobes (single clk, not ce-qualified)
//   reg_addr, reg_wdata address (0..N_SRC-1 = IC[i], 8 = ISPR) and write data
//   reg_rdata           registered read data, 1-cycle latency
//   irq_request         request to the core
//   irq_vector          vector number, valid while irq_request = 1
//   irq_ack, irq_fini   core accepted the request / executed FINT-RETI
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; arbitrate among eligible sources
// PEND  | vector latched and presented; wait for ack or drop if cancelled
module v35_intc #(
  parameter int N_SRC    = 8,
  parameter int VEC_BASE = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_cycle,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] src_pol,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [3:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  output logic             irq_request,
  output logic [7:0]       irq_vector,
  input  logic             irq_ack,
  input  logic             irq_fini
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [7:0] VEC_BASE_8 = 8'(VEC_BASE);

  logic [N_SRC-1:0] ic_if;
  logic [N_SRC-1:0] ic_mk;
  logic [2:0]       ic_pr [N_SRC];
  logic [7:0]       ispr;
  logic [N_SRC-1:0] prev;
  state_t           state;
  logic [2:0]       win_idx;

  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] wr_ic;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] if_nxt;
  logic [7:0]       ispr_nxt;
  logic [7:0]       rd_val;
  logic [2:0]       sel_idx;
  logic [2:0]       best_pr;
  logic             any_elig;
  logic             ack_act;
  logic             fini_act;
  logic             wr_ispr;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[5:3];

  assign ack_act  = ce_cycle & irq_ack & (state == PEND);
  assign fini_act = ce_cycle & irq_fini;
  assign wr_ispr  = reg_wr & (reg_addr == 4'd8);

  // A source is eligible only if no level at or above its own priority
  // (PR..0) is in service.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      edge_set[i] = ce_cycle & (src_in[i] ^ prev[i]) & ~(src_in[i] ^ src_pol[i]);
      wr_ic[i]    = reg_wr & (reg_addr == 4'(i));
      elig[i]     = ic_if[i] & ~ic_mk[i] &
                    ((ispr & (8'hFF >> (3'd7 - ic_pr[i]))) == 8'h00);
    end
  end

  // Strict less-than while scanning upward gives lowest index on ties.
  always_comb begin
    any_elig = 1'b0;
    sel_idx  = 3'd0;
    best_pr  = 3'd7;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i] && (!any_elig || ic_pr[i] < best_pr)) begin
        any_elig = 1'b1;
        sel_idx  = 3'(i);
        best_pr  = ic_pr[i];
      end
    end
  end

  // Ack clears, a register write overrides, and an edge always wins.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      if_nxt[i] = ic_if[i];
      if (ack_act && win_idx == 3'(i)) if_nxt[i] = 1'b0;
      if (wr_ic[i])                    if_nxt[i] = reg_wdata[7];
      if (edge_set[i])                 if_nxt[i] = 1'b1;
    end
  end

  // Fini retires the lowest set bit of the old ISPR before the ack bit is
  // ORed in; a software ISPR write loses to either handshake update.
  always_comb begin
    ispr_nxt = ispr;
    if (fini_act || ack_act) begin
      if (fini_act) ispr_nxt = ispr & (ispr - 8'd1);
      if (ack_act)  ispr_nxt = ispr_nxt | (8'd1 << ic_pr[win_idx]);
    end else if (wr_ispr) begin
      ispr_nxt = reg_wdata;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (reg_addr == 4'(i)) rd_val = {ic_if[i], ic_mk[i], 3'b000, ic_pr[i]};
    end
    if (reg_addr == 4'd8) rd_val = ispr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ic_if <= '0;
      ic_mk <= '1;
      for (int i = 0; i < N_SRC; i++) ic_pr[i] <= 3'd7;
      ispr        <= 8'h00;
      prev        <= src_in;
      state       <= IDLE;
      win_idx     <= 3'd0;
      irq_request <= 1'b0;
      irq_vector  <= 8'h00;
      reg_rdata   <= 8'h00;
    end else begin
      ic_if <= if_nxt;
      for (int i = 0; i < N_SRC; i++) begin
        if (wr_ic[i]) begin
          ic_mk[i] <= reg_wdata[6];
          ic_pr[i] <= reg_wdata[2:0];
        end
      end
      ispr <= ispr_nxt;
      if (reg_rd) reg_rdata <= rd_val;
      if (ce_cycle) begin
        prev <= src_in;
        case (state)
          IDLE: begin
            if (any_elig) begin
              win_idx     <= sel_idx;
              irq_vector  <= VEC_BASE_8 + {5'd0, sel_idx};
              irq_request <= 1'b1;
              state       <= PEND;
            end
          end
          PEND: begin
            if (ack_act || !elig[win_idx]) begin
              irq_request <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
